// File: rtl/wb_sram_slave.sv
// ---------------------------------------------------------------------------
// wb_sram_slave
// Wishbone classic-cycle slave wrapping a single-port, word-addressed SRAM.
// Serves as source/destination memory for the DMA controller's master port.
// A request is captured in IDLE, held for WAIT_STATES cycles, then terminated
// in a single RESP cycle with either ack (normal) or err (misaligned or
// outside the window [BASE_ADDR, BASE_ADDR + DEPTH*DATA_WIDTH/8)).
//
// Ports:
//   i_clk, i_rst_n  clock; asynchronous active-low reset
//   i_wb_cyc/stb    bus cycle / strobe
//   i_wb_we         1 = write, 0 = read
//   i_wb_adr        byte address
//   i_wb_sel        byte-lane enables (writes only)
//   i_wb_dat        write data
//   o_wb_dat        read data, non-zero only during an acked read
//   o_wb_ack        normal termination
//   o_wb_err        error termination
//   o_wb_stall      1 while a request is in flight
//   o_err_count     saturating count of error terminations
// ---------------------------------------------------------------------------
module wb_sram_slave #(
  parameter int unsigned             DATA_WIDTH  = 32,
  parameter int unsigned             ADDR_WIDTH  = 32,
  parameter int unsigned             DEPTH       = 256,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR   = '0,
  parameter int unsigned             WAIT_STATES = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_wb_cyc,
  input  logic                      i_wb_stb,
  input  logic                      i_wb_we,
  input  logic [ADDR_WIDTH-1:0]     i_wb_adr,
  input  logic [DATA_WIDTH/8-1:0]   i_wb_sel,
  input  logic [DATA_WIDTH-1:0]     i_wb_dat,
  output logic [DATA_WIDTH-1:0]     o_wb_dat,
  output logic                      o_wb_ack,
  output logic                      o_wb_err,
  output logic                      o_wb_stall,
  output logic [7:0]                o_err_count
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned LSB   = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CW    = 8;

  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(DEPTH * BYTES);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(BYTES - 1);
  localparam logic [CNT_W-1:0]      WAIT_LOAD = CNT_W'(WAIT_STATES);
  localparam logic [CW-1:0]         CNT_MAX   = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic                    we_q, we_d;
  logic [BYTES-1:0]        sel_q, sel_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    stall_q, stall_d;
  logic [CW-1:0]           err_cnt_q, err_cnt_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0]   req_adr_c;
  logic                    req_we_c;
  logic [BYTES-1:0]        req_sel_c;
  logic [DATA_WIDTH-1:0]   req_wdat_c;
  logic [ADDR_WIDTH-1:0]   offset_c;
  logic [IDX_W-1:0]        idx_c;
  logic                    req_err_c;
  logic [DATA_WIDTH-1:0]   rd_word_c;
  logic                    enter_resp_c;
  logic                    mem_wr_c;

  // With zero wait states RESP is entered on the capture edge itself, so the
  // decode must look at the live bus in IDLE and the latched copy otherwise.
  always_comb begin : req_mux
    if (state_q == ST_IDLE) begin
      req_adr_c  = i_wb_adr;
      req_we_c   = i_wb_we;
      req_sel_c  = i_wb_sel;
      req_wdat_c = i_wb_dat;
    end else begin
      req_adr_c  = adr_q;
      req_we_c   = we_q;
      req_sel_c  = sel_q;
      req_wdat_c = wdat_q;
    end
  end

  // Address decode; addresses below BASE_ADDR wrap to huge offsets.
  always_comb begin : addr_decode
    offset_c  = req_adr_c - BASE_ADDR;
    idx_c     = offset_c[LSB +: IDX_W];
    req_err_c = ((offset_c & LANE_MASK) != '0) || (offset_c >= MEM_BYTES);
    rd_word_c = mem_q[idx_c];
  end

  // Next-state and registered-output next values.
  always_comb begin : fsm_next
    state_d   = state_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    we_d      = we_q;
    sel_d     = sel_q;
    wdat_d    = wdat_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          adr_d   = i_wb_adr;
          we_d    = i_wb_we;
          sel_d   = i_wb_sel;
          wdat_d  = i_wb_dat;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_STATES != 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!i_wb_cyc) begin
          // Master abandoned the cycle: drop the request silently.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    enter_resp_c = (state_d == ST_RESP) && (state_q != ST_RESP);
    mem_wr_c     = enter_resp_c && req_we_c && !req_err_c && i_rst_n;

    ack_d     = enter_resp_c && !req_err_c;
    err_d     = enter_resp_c && req_err_c;
    dat_d     = (enter_resp_c && !req_we_c && !req_err_c) ? rd_word_c : '0;
    stall_d   = (state_d != ST_IDLE);
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CW'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin : fsm_regs
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      adr_q     <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      wdat_q    <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      stall_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      wdat_q    <= wdat_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      stall_q   <= stall_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage array: no reset, byte-lane write on the edge entering RESP.
  always_ff @(posedge i_clk) begin : mem_write
    if (mem_wr_c) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (req_sel_c[b]) begin
          mem_q[idx_c][b*8 +: 8] <= req_wdat_c[b*8 +: 8];
        end
      end
    end
  end

  assign o_wb_dat    = dat_q;
  assign o_wb_ack    = ack_q;
  assign o_wb_err    = err_q;
  assign o_wb_stall  = stall_q;
  assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_wb_sram_slave
// Self-checking bench. Instance "a" uses WAIT_STATES = 2, instance "b" uses
// WAIT_STATES = 0; both share the bus inputs. A word-array reference model
// tracks the contents and error count of instance "a".
// ---------------------------------------------------------------------------
module tb_wb_sram_slave;

  localparam int unsigned   DEPTH   = 256;
  localparam logic [31:0]   BASE    = 32'h2000_0000;
  localparam int            EXP_LAT = 3;  // WAIT_STATES + 1 cycles after capture

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;

  logic [31:0] a_dat, b_dat;
  logic        a_ack, a_err, a_stall, b_ack, b_err, b_stall;
  logic [7:0]  a_errcnt, b_errcnt;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl_mem [DEPTH];
  bit          mdl_wr  [DEPTH];
  int          mdl_errcnt;

  logic [31:0] r_dat;
  logic        r_ack, r_err;
  int          r_lat;
  bit          r_stall_ok;

  always #5 clk = ~clk;

  wb_sram_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH),
    .BASE_ADDR(BASE), .WAIT_STATES(2)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .i_wb_we(we), .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_dat(wdat),
    .o_wb_dat(a_dat), .o_wb_ack(a_ack), .o_wb_err(a_err),
    .o_wb_stall(a_stall), .o_err_count(a_errcnt)
  );

  wb_sram_slave #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH),
    .BASE_ADDR(BASE), .WAIT_STATES(0)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .i_wb_we(we), .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_dat(wdat),
    .o_wb_dat(b_dat), .o_wb_ack(b_ack), .o_wb_err(b_err),
    .o_wb_stall(b_stall), .o_err_count(b_errcnt)
  );

  // ---------------- reference model ----------------
  function automatic bit mdl_is_err(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off[1:0] != 2'b00) || (off >= 32'd1024);
  endfunction

  function automatic int mdl_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'(off[9:2]);
  endfunction

  task automatic mdl_apply(input bit w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] d);
    int i;
    if (mdl_is_err(a)) begin
      if (mdl_errcnt < 255) mdl_errcnt++;
    end else if (w) begin
      i = mdl_idx(a);
      for (int b = 0; b < 4; b++)
        if (s[b]) mdl_mem[i][8*b +: 8] = d[8*b +: 8];
      mdl_wr[i] = mdl_wr[i] | (s == 4'hF);
    end
  endtask

  // One transaction on instance a; optionally scrambles the bus while waiting.
  task automatic do_txn(input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, input bit scramble);
    r_ack = 1'b0; r_err = 1'b0; r_dat = '0; r_lat = 0; r_stall_ok = 1'b1;
    @(negedge clk);
    if (a_stall !== 1'b0) r_stall_ok = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (a_stall !== 1'b1) r_stall_ok = 1'b0;
      if (a_ack === 1'b1 || a_err === 1'b1) begin
        r_ack = a_ack; r_err = a_err; r_dat = a_dat; r_lat = k;
        break;
      end
      if (scramble) begin
        adr = $urandom; wdat = $urandom; we = 1'($urandom); sel = 4'($urandom);
      end
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (a_dat !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h expected 0", a_dat); end
    checks++; if (a_ack !== 1'b0 || a_err !== 1'b0) begin errors++; $display("FAIL reset_term: got ack=%b err=%b expected 0", a_ack, a_err); end
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", a_stall); end
    checks++; if (a_errcnt !== 8'd0) begin errors++; $display("FAIL reset_errcnt: got %0d expected 0", a_errcnt); end
    checks++; if ({b_ack, b_err, b_stall} !== 3'b000) begin errors++; $display("FAIL reset_b: got %b expected 000", {b_ack, b_err, b_stall}); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    do_txn(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0);
    mdl_apply(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
    checks++; if (r_ack !== 1'b1 || r_err !== 1'b0) begin errors++; $display("FAIL basic_wr_ack: got ack=%b err=%b expected ack=1 err=0", r_ack, r_err); end
    checks++; if (r_lat !== EXP_LAT) begin errors++; $display("FAIL basic_wr_lat: got %0d expected %0d", r_lat, EXP_LAT); end
    checks++; if (r_stall_ok !== 1'b1) begin errors++; $display("FAIL basic_wr_stall: got stall pattern bad expected ok"); end
    do_txn(1'b0, BASE + 32'h10, 4'h0, 32'h0, 1'b0);
    checks++; if (r_ack !== 1'b1 || r_err !== 1'b0) begin errors++; $display("FAIL basic_rd_ack: got ack=%b err=%b expected ack=1 err=0", r_ack, r_err); end
    checks++; if (r_lat !== EXP_LAT) begin errors++; $display("FAIL basic_rd_lat: got %0d expected %0d", r_lat, EXP_LAT); end
    checks++; if (r_dat !== 32'hDEAD_BEEF) begin errors++; $display("FAIL basic_rd_dat: got %h expected deadbeef", r_dat); end
    checks++; if (r_stall_ok !== 1'b1) begin errors++; $display("FAIL basic_rd_stall: got stall pattern bad expected ok"); end
    @(negedge clk);
    checks++; if (a_dat !== 32'h0 || a_ack !== 1'b0) begin errors++; $display("FAIL basic_after_resp: got dat=%h ack=%b expected 0", a_dat, a_ack); end
  endtask

  task automatic test_byte_lanes;
    do_txn(1'b1, BASE + 32'h20, 4'hF, 32'h1122_3344, 1'b0);
    mdl_apply(1'b1, BASE + 32'h20, 4'hF, 32'h1122_3344);
    do_txn(1'b1, BASE + 32'h20, 4'b0101, 32'hAABB_CCDD, 1'b0);
    mdl_apply(1'b1, BASE + 32'h20, 4'b0101, 32'hAABB_CCDD);
    checks++; if (r_ack !== 1'b1) begin errors++; $display("FAIL lanes_wr_ack: got %b expected 1", r_ack); end
    do_txn(1'b1, BASE + 32'h20, 4'h0, 32'hFFFF_FFFF, 1'b0);
    checks++; if (r_ack !== 1'b1) begin errors++; $display("FAIL lanes_sel0_ack: got %b expected 1", r_ack); end
    do_txn(1'b0, BASE + 32'h20, 4'h0, 32'h0, 1'b0);
    checks++; if (r_dat !== 32'h11BB_33DD) begin errors++; $display("FAIL lanes_rd_dat: got %h expected 11bb33dd", r_dat); end
  endtask

  task automatic test_errors;
    logic [31:0] ea [3];
    logic [31:0] a;
    ea[0] = 32'h2000_0400; ea[1] = 32'h1FFF_FFFC; ea[2] = 32'h2000_0002;
    for (int i = 0; i < 3; i++) begin
      do_txn(1'b0, ea[i], 4'hF, 32'h0, 1'b0);
      mdl_apply(1'b0, ea[i], 4'hF, 32'h0);
      checks++; if (r_err !== 1'b1 || r_ack !== 1'b0) begin errors++; $display("FAIL err_term_%0d: got ack=%b err=%b expected ack=0 err=1", i, r_ack, r_err); end
      checks++; if (r_dat !== 32'h0) begin errors++; $display("FAIL err_dat_%0d: got %h expected 0", i, r_dat); end
    end
    checks++; if (a_errcnt !== 8'(mdl_errcnt)) begin errors++; $display("FAIL err_count3: got %0d expected %0d", a_errcnt, mdl_errcnt); end
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if (!mdl_is_err(a)) a = a | 32'h1;
      do_txn(1'($urandom), a, 4'($urandom), $urandom, 1'b0);
      mdl_apply(1'b0, a, 4'h0, 32'h0);
      checks++; if (r_err !== 1'b1 || r_ack !== 1'b0) begin errors++; $display("FAIL err_loop_%0d: got ack=%b err=%b adr=%h expected err", i, r_ack, r_err, a); end
    end
    checks++; if (a_errcnt !== 8'd255) begin errors++; $display("FAIL err_saturate: got %0d expected 255", a_errcnt); end
  endtask

  task automatic test_abort;
    bit seen;
    do_txn(1'b1, BASE + 32'h30, 4'hF, 32'h0, 1'b0);
    mdl_apply(1'b1, BASE + 32'h30, 4'hF, 32'h0);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h30; sel = 4'hF; wdat = 32'h5555_5555;
    @(posedge clk);
    @(negedge clk);
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL abort_wait_stall: got %b expected 1", a_stall); end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL abort_idle_stall: got %b expected 0", a_stall); end
    seen = (a_ack === 1'b1) || (a_err === 1'b1);
    repeat (4) begin
      @(negedge clk);
      if (a_ack === 1'b1 || a_err === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_term: got termination expected none"); end
    do_txn(1'b0, BASE + 32'h30, 4'hF, 32'h0, 1'b0);
    checks++; if (r_ack !== 1'b1 || r_dat !== 32'h0) begin errors++; $display("FAIL abort_readback: got ack=%b dat=%h expected ack=1 dat=0", r_ack, r_dat); end
    checks++; if (a_errcnt !== 8'(mdl_errcnt)) begin errors++; $display("FAIL abort_errcnt: got %0d expected %0d", a_errcnt, mdl_errcnt); end
  endtask

  task automatic test_random;
    logic [31:0] a, d;
    logic [3:0]  s;
    bit          w, e_err, e_known;
    logic [31:0] e_dat;
    int          pick;
    for (int n = 0; n < 150; n++) begin
      pick = $urandom_range(0, 99);
      if (pick < 70)      a = BASE + ($urandom_range(0, DEPTH - 1) << 2);
      else if (pick < 85) a = BASE + ($urandom_range(0, 1023) | 32'h1);
      else                a = $urandom;
      w = 1'($urandom); s = 4'($urandom); d = $urandom;
      e_err   = mdl_is_err(a);
      e_known = 1'b1;
      e_dat   = 32'h0;
      if (!e_err && !w) begin
        e_known = mdl_wr[mdl_idx(a)];
        e_dat   = mdl_mem[mdl_idx(a)];
      end
      do_txn(w, a, s, d, 1'b1);
      mdl_apply(w, a, s, d);
      checks++; if (r_err !== e_err || r_ack !== !e_err) begin errors++; $display("FAIL rnd_term_%0d: got ack=%b err=%b adr=%h expected err=%b", n, r_ack, r_err, a, e_err); end
      checks++; if (r_lat !== EXP_LAT) begin errors++; $display("FAIL rnd_lat_%0d: got %0d expected %0d", n, r_lat, EXP_LAT); end
      checks++; if (r_stall_ok !== 1'b1) begin errors++; $display("FAIL rnd_stall_%0d: got stall pattern bad expected ok", n); end
      if (e_known) begin
        checks++; if (r_dat !== e_dat) begin errors++; $display("FAIL rnd_dat_%0d: got %h expected %h adr=%h we=%b", n, r_dat, e_dat, a, w); end
      end
      checks++; if (a_errcnt !== 8'(mdl_errcnt)) begin errors++; $display("FAIL rnd_errcnt_%0d: got %0d expected %0d", n, a_errcnt, mdl_errcnt); end
    end
  endtask

  task automatic test_reset_mid;
    do_txn(1'b1, BASE + 32'h40, 4'hF, 32'hCAFE_F00D, 1'b0);
    mdl_apply(1'b1, BASE + 32'h40, 4'hF, 32'hCAFE_F00D);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h40; sel = 4'hF; wdat = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    mdl_errcnt = 0;
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b expected 0", a_stall); end
    checks++; if ({a_ack, a_err, a_dat} !== 34'h0) begin errors++; $display("FAIL rstmid_outs: got ack=%b err=%b dat=%h expected 0", a_ack, a_err, a_dat); end
    checks++; if (a_errcnt !== 8'(mdl_errcnt)) begin errors++; $display("FAIL rstmid_errcnt: got %0d expected 0", a_errcnt); end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b0, BASE + 32'h40, 4'hF, 32'h0, 1'b0);
    checks++; if (r_ack !== 1'b1 || r_lat !== EXP_LAT) begin errors++; $display("FAIL rstmid_next_ack: got ack=%b lat=%0d expected ack=1 lat=%0d", r_ack, r_lat, EXP_LAT); end
    checks++; if (r_dat !== mdl_mem[mdl_idx(BASE + 32'h40)]) begin errors++; $display("FAIL rstmid_nowrite: got %h expected %h", r_dat, mdl_mem[mdl_idx(BASE + 32'h40)]); end
    do_txn(1'b0, 32'h1FFF_FFFC, 4'hF, 32'h0, 1'b0);
    mdl_apply(1'b0, 32'h1FFF_FFFC, 4'hF, 32'h0);
    checks++; if (r_err !== 1'b1 || a_errcnt !== 8'(mdl_errcnt)) begin errors++; $display("FAIL rstmid_errcnt_inc: got err=%b cnt=%0d expected err=1 cnt=%0d", r_err, a_errcnt, mdl_errcnt); end
  endtask

  // Instance b (zero wait states): read then write with strobe held.
  task automatic test_back_to_back;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE; sel = 4'hF; wdat = 32'h0BAD_CAFE;
    @(negedge clk);
    checks++; if (b_ack !== 1'b1) begin errors++; $display("FAIL b2b_prep_ack: got %b expected 1", b_ack); end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF; wdat = 32'h0;
    @(negedge clk);
    checks++; if (b_ack !== 1'b1 || b_dat !== 32'h0BAD_CAFE || b_stall !== 1'b1) begin errors++; $display("FAIL b2b_c1: got ack=%b dat=%h stall=%b expected ack=1 dat=0badcafe stall=1", b_ack, b_dat, b_stall); end
    we = 1'b1; adr = BASE + 32'h100; wdat = 32'h600D_F00D;
    @(negedge clk);
    checks++; if (b_ack !== 1'b0 || b_err !== 1'b0 || b_stall !== 1'b0) begin errors++; $display("FAIL b2b_c2: got ack=%b err=%b stall=%b expected 0 0 0", b_ack, b_err, b_stall); end
    @(negedge clk);
    checks++; if (b_ack !== 1'b1 || b_dat !== 32'h0 || b_stall !== 1'b1) begin errors++; $display("FAIL b2b_c3: got ack=%b dat=%h stall=%b expected ack=1 dat=0 stall=1", b_ack, b_dat, b_stall); end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    checks++; if (b_ack !== 1'b0 || b_stall !== 1'b0) begin errors++; $display("FAIL b2b_c4: got ack=%b stall=%b expected 0 0", b_ack, b_stall); end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h100;
    @(negedge clk);
    checks++; if (b_ack !== 1'b1 || b_dat !== 32'h600D_F00D) begin errors++; $display("FAIL b2b_readback: got ack=%b dat=%h expected ack=1 dat=600df00d", b_ack, b_dat); end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; sel = '0; wdat = '0;
    mdl_errcnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mdl_wr[i]  = 1'b0;
      mdl_mem[i] = '0;
    end
    test_reset;
    test_basic;
    test_byte_lanes;
    test_errors;
    test_abort;
    test_random;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
